// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises per-CPU instruction and data cache requests onto
// a single RAM port. One request is registered at a time, the RAM is driven
// until it reports completion, and the requester is released with a one-cycle
// low pulse on its wait bit while the load buses carry the registered data.
module memory_arbiter #(
  parameter int CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*32-1:0]   iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS*32-1:0]   iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS*32-1:0]   dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        rr_q, rr_d;
  logic        src_cpu_q, src_cpu_d;
  logic        src_d_q, src_d_d;       // 1 = data request, 0 = instruction fetch
  logic        is_write_q, is_write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  // Requests widened to two slots so a single-CPU build never indexes past
  // its ports; the unused slot simply never requests.
  logic [1:0]  i_req, d_req, d_wr;
  logic [31:0] i_addr_x [2];
  logic [31:0] d_addr_x [2];
  logic [31:0] d_data_x [2];

  // Unpack the per-CPU request buses into fixed two-entry form.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it holding a value and inferring a latch.
    i_req = '0;
    d_req = '0;
    d_wr  = '0;
    for (int c = 0; c < 2; c++) begin
      i_addr_x[c] = '0;
      d_addr_x[c] = '0;
      d_data_x[c] = '0;
    end
    for (int c = 0; c < CPUS; c++) begin
      i_req[c]    = iREN[c];
      d_req[c]    = dREN[c] | dWEN[c];
      d_wr[c]     = dWEN[c];
      i_addr_x[c] = iaddr[c*32 +: 32];
      d_addr_x[c] = daddr[c*32 +: 32];
      d_data_x[c] = dstore[c*32 +: 32];
    end
  end

  logic other_cpu;
  logic grant;
  logic sel_cpu;
  logic sel_d;

  // Pick the winner: data before instruction, CPU rr before the other CPU.
  always_comb begin
    other_cpu = ~rr_q;
    grant     = 1'b1;
    sel_cpu   = rr_q;
    sel_d     = 1'b1;
    if (d_req[rr_q]) begin
      sel_cpu = rr_q;
      sel_d   = 1'b1;
    end else if (d_req[other_cpu]) begin
      sel_cpu = other_cpu;
      sel_d   = 1'b1;
    end else if (i_req[rr_q]) begin
      sel_cpu = rr_q;
      sel_d   = 1'b0;
    end else if (i_req[other_cpu]) begin
      sel_cpu = other_cpu;
      sel_d   = 1'b0;
    end else begin
      grant   = 1'b0;
    end
  end

  // Next-state logic: latch the grant in IDLE, wait out the RAM in ACCESS,
  // release the requester for one cycle in RESP.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    src_cpu_d  = src_cpu_q;
    src_d_d    = src_d_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          src_cpu_d  = sel_cpu;
          src_d_d    = sel_d;
          // A data request carrying both dREN and dWEN is treated as a write.
          is_write_d = sel_d & d_wr[sel_cpu];
          addr_d     = sel_d ? d_addr_x[sel_cpu] : i_addr_x[sel_cpu];
          wdata_d    = sel_d ? d_data_x[sel_cpu] : 32'd0;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (ramstate == RAM_ACCESS) begin
          rdata_d = ramload;
          state_d = ST_RESP;
        end else if (ramstate == RAM_ERROR) begin
          // Drop back without a response; the still-pending request is
          // simply arbitrated again.
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (CPUS == 2) rr_d = ~rr_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request latches; everything returns to a known value on reset
  // because the load buses are visible outputs straight from rdata.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      src_cpu_q  <= 1'b0;
      src_d_q    <= 1'b0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this edge.
      state_q    <= state_d;
      rr_q       <= rr_d;
      src_cpu_q  <= src_cpu_d;
      src_d_q    <= src_d_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  logic [1:0] iwait_x, dwait_x;

  // Outputs decode from registered state only, so an asynchronous reset
  // drops the RAM enables and wait pulses immediately.
  always_comb begin
    iwait_x = 2'b11;
    dwait_x = 2'b11;
    if (state_q == ST_RESP) begin
      if (src_d_q) dwait_x[src_cpu_q] = 1'b0;
      else         iwait_x[src_cpu_q] = 1'b0;
    end
    ramREN   = (state_q == ST_ACCESS) & ~is_write_q;
    ramWEN   = (state_q == ST_ACCESS) &  is_write_q;
    ramaddr  = (state_q == ST_ACCESS) ? addr_q  : 32'd0;
    ramstore = (state_q == ST_ACCESS) ? wdata_q : 32'd0;
  end

  assign iwait = iwait_x[CPUS-1:0];
  assign dwait = dwait_x[CPUS-1:0];
  assign iload = {CPUS{rdata_q}};
  assign dload = {CPUS{rdata_q}};

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential responder on the cache side of `cache_control_if`. It services instruction-fetch requests from each CPU's `icache` and read/write requests from each `dcache`, and serialises them onto the single RAM port. It registers one request at a time, drives RAM until the access completes, then releases the requester with a single-cycle `iwait`/`dwait` low pulse and registered load data. It sits between the per-CPU caches and the system RAM, replacing the combinational memory controller.

## Interface

Parameters:
- `CPUS`, default 2: number of CPUs served (1 or 2).

Ports (all `word_t` are 32 bits; port names match the `cache_control_if` `cc`/`ram` members):
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `iREN` in CPUS: instruction read request, per CPU.
- `iaddr` in CPUS×32: instruction address, per CPU.
- `iwait` out CPUS: instruction wait; 1 = not serviced this cycle.
- `iload` out CPUS×32: instruction data; valid when `iwait` = 0.
- `dREN` in CPUS: data read request.
- `dWEN` in CPUS: data write request.
- `daddr` in CPUS×32: data address.
- `dstore` in CPUS×32: data write value.
- `dwait` out CPUS: data wait.
- `dload` out CPUS×32: data read value.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data.
- `ramstate` in 2: `ramstate_t` from `cpu_types_pkg`. Encodings: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation

- FSM states: IDLE, ACCESS, RESP.
- **IDLE.** Pick one pending request.
  - Data requests (`dREN|dWEN`) take priority over instruction requests.
  - Among CPUs, the round-robin pointer `rr` picks the winner. `rr` resets to 0.
  - Order of selection: data from CPU `rr`, then data from the other CPU, then instruction from CPU `rr`, then instruction from the other CPU.
  - Latch `src_cpu`, `src_type` (I/D), `is_write` (`dWEN`; a request with both `dWEN` and `dREN` set counts as a write), address, and store data. Go to ACCESS.
  - With no request pending, stay in IDLE.
- **ACCESS.** Drive `ramaddr` and `ramstore` from the latched values, and `ramREN = ~is_write`, `ramWEN = is_write`.
  - `ramstate` = ACCESS: capture `ramload` into `rdata`, go to RESP.
  - `ramstate` = ERROR: deassert RAM enables and go to IDLE without a response. The request is re-arbitrated.
  - FREE or BUSY: remain in ACCESS.
- **RESP.** Drive the selected wait bit (`iwait[src_cpu]` or `dwait[src_cpu]`) to 0 for exactly this cycle.
  - The matching `iload`/`dload` equals `rdata`.
  - For a write, `dload` = `rdata` (don't-care, but deterministic).
  - Toggle `rr` when `CPUS` = 2, then go to IDLE.
- All wait bits are 1 except the single RESP pulse. Only one wait bit is low in any cycle.
- `iload`/`dload` outputs hold `rdata` for every CPU at all times; only the wait bit qualifies them.
- Inputs are sampled only in IDLE. Changes to address or data during ACCESS are ignored.
- If a request is withdrawn mid-ACCESS, the RAM access still completes and the RESP pulse is still issued.
- An I-request from CPU0 and a D-request from CPU1 are never merged; each gets a separate ACCESS.

## Timing

- Reset values:
  - state = IDLE, `rr` = 0, `rdata` = 0.
  - `iwait` and `dwait` all 1s; `iload` and `dload` all 0.
  - `ramREN` = `ramWEN` = 0; `ramaddr` = `ramstore` = 0.
- Reset asserted mid-ACCESS aborts immediately: RAM enables drop asynchronously and no response is issued.
- RAM outputs are combinational from the registered state and latches. They are 0 outside ACCESS.
- Latency is measured from the first edge that sees the request in IDLE (edge t0):
  - ACCESS occupies the cycle after t0.
  - If `ramstate` = ACCESS in that cycle, RESP (wait low) occurs in the next cycle.
  - Minimum request-to-release is 2 cycles. Each additional BUSY cycle adds 1.
- After RESP there is one IDLE cycle before the next grant, so back-to-back service spacing is at least 3 cycles.
- A requester that keeps its request asserted after its wait pulse is re-served as a new request.

## Test plan

- **Single I-fetch, no RAM latency.** CPU0 `iREN` = 1, `iaddr` = 0x40; RAM returns ACCESS on the first cycle with `ramload` = 0x2402_0001.
  - Expect: `ramREN` = 1 and `ramaddr` = 0x40 for 1 cycle; `iwait[0]` = 0 exactly 2 cycles after the request; `iload[0]` = 0x24020001.
- **D-over-I priority.** Same cycle: CPU0 `iREN` @0x0 and CPU0 `dWEN` @0x80 with `dstore` = 0xDEAD_BEEF.
  - Expect: the write is issued first (`ramWEN` = 1, `ramstore` = 0xDEADBEEF) with a `dwait[0]` pulse; then the fetch at 0x0 with an `iwait[0]` pulse.
- **Round-robin.** Both CPUs hold `dREN` continuously at 0x100 and 0x200.
  - Expect: grants alternate CPU0, CPU1, CPU0…; wait pulses are separated by at least 3 cycles; never both low together.
- **RAM latency and error.** RAM reports BUSY for 3 cycles, then ACCESS.
  - Expect: release 5 cycles after the request.
  - Separately, return ERROR once: no wait pulse, the request is retried, and released on the following ACCESS.
- **Reset mid-access.** Deassert `nRST` while in ACCESS.
  - Expect: all waits 1 and RAM enables 0 immediately; after reset, the pending request is served with `rr` = 0.
